// File: rtl/adc_din_sequencer.sv
// adc_din_sequencer: round-robin serial ADC command/capture sequencer.
// Each frame sends a WORD_W-bit command (the channel address at ADDR_LSB)
// on Din, MSB first. It captures WORD_W bits of dout on the rising edges of
// sclk, then reports the captured word with data/data_ch/data_valid.
// Optional feature: define ADC_DIN_AUTOSCAN_EN so that, after the first
// start, frames chain back to back through the enabled channels.

module adc_din_sequencer #(
   parameter int unsigned CH_W     = 3,
   parameter int unsigned WORD_W   = 16,
   parameter int unsigned ADDR_LSB = 11,
   parameter int unsigned HALF     = 2,
   parameter int unsigned GAP_CYC  = 3
) (
   input  logic                 clk_25M,
   input  logic                 rst,
   input  logic                 start,
   input  logic [2**CH_W-1:0]   ch_mask,
   input  logic                 dout,
   output logic                 sclk,
   output logic                 cs_n,
   output logic                 Din,
   output logic                 busy,
   output logic                 data_valid,
   output logic [WORD_W-1:0]    data,
   output logic [CH_W-1:0]      data_ch
);

   localparam int unsigned N_CH    = 2**CH_W;
   localparam int unsigned CNT_MAX = (HALF > GAP_CYC) ? HALF : GAP_CYC;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam int unsigned BIT_W   = $clog2(WORD_W + 1);

   typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic [BIT_W-1:0]    bit_idx;
   logic                phase_hi;
   logic [WORD_W-1:0]   tx;
   logic [WORD_W-1:0]   cap;
   logic [CH_W-1:0]     cur_ch;
   logic                have_last;

   logic [CH_W-1:0]     base;
   logic                sel_found;
   logic [CH_W-1:0]     sel_ch;
   logic                half_end;
   logic                gap_end;
   logic                last_bit;
   logic                launch;

   // First enabled channel at or after base, wrapping around the channel space
   function automatic logic [CH_W:0] pick_next(input logic [N_CH-1:0] mask,
                                               input logic [CH_W-1:0] from);
      logic            found;
      logic [CH_W-1:0] idx;
      logic [CH_W-1:0] res;
      found = 1'b0;
      res   = '0;
      for (int k = 0; k < int'(N_CH); k++) begin
         idx = from + CH_W'(k);
         if (!found && mask[idx]) begin
            found = 1'b1;
            res   = idx;
         end
      end
      return {found, res};
   endfunction

   // Command word: zero except for the channel address field
   function automatic logic [WORD_W-1:0] build_word(input logic [CH_W-1:0] ch);
      logic [WORD_W-1:0] w;
      w = '0;
      w[ADDR_LSB +: CH_W] = ch;
      return w;
   endfunction

   // Search starts just past the last served channel, or at 0 after reset
   assign base = have_last ? cur_ch + 1'b1 : '0;
   assign {sel_found, sel_ch} = pick_next(ch_mask, base);

   assign half_end = (cnt == CNT_W'(HALF - 1));
   assign gap_end  = (cnt == CNT_W'(GAP_CYC - 1));
   assign last_bit = (bit_idx == BIT_W'(WORD_W - 1));

   // Frame launch: from IDLE on start, or straight out of GAP when autoscanning
`ifdef ADC_DIN_AUTOSCAN_EN
   assign launch = sel_found && (((state == IDLE) && start) || ((state == GAP) && gap_end));
`else
   assign launch = sel_found && (state == IDLE) && start;
`endif

   // The command shift register's MSB drives Din directly
   assign Din = tx[WORD_W-1];

   // Sequencer FSM with registered serial and result outputs
   always_ff @(posedge clk_25M) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         phase_hi   <= 1'b0;
         tx         <= '0;
         cap        <= '0;
         cur_ch     <= '0;
         have_last  <= 1'b0;
         sclk       <= 1'b1;
         cs_n       <= 1'b1;
         busy       <= 1'b0;
         data_valid <= 1'b0;
         data       <= '0;
         data_ch    <= '0;
      end else begin
         data_valid <= 1'b0;
         if (launch) begin
            state     <= SETUP;
            cnt       <= '0;
            cur_ch    <= sel_ch;
            have_last <= 1'b1;
            tx        <= build_word(sel_ch);
            cs_n      <= 1'b0;
            sclk      <= 1'b1;
            busy      <= 1'b1;
         end else begin
            case (state)
               IDLE: begin
               end
               SETUP: begin
                  if (half_end) begin
                     state    <= SHIFT;
                     cnt      <= '0;
                     bit_idx  <= '0;
                     phase_hi <= 1'b0;
                     sclk     <= 1'b0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               SHIFT: begin
                  if (!half_end) begin
                     cnt <= cnt + 1'b1;
                  end else begin
                     cnt <= '0;
                     if (!phase_hi) begin
                        // sclk rises: capture the converter's bit
                        phase_hi <= 1'b1;
                        sclk     <= 1'b1;
                        cap      <= {cap[WORD_W-2:0], dout};
                     end else if (last_bit) begin
                        state      <= GAP;
                        cs_n       <= 1'b1;
                        tx         <= '0;
                        data_valid <= 1'b1;
                        data       <= cap;
                        data_ch    <= cur_ch;
                     end else begin
                        // sclk falls: present the next command bit
                        bit_idx  <= bit_idx + 1'b1;
                        phase_hi <= 1'b0;
                        sclk     <= 1'b0;
                        tx       <= {tx[WORD_W-2:0], 1'b0};
                     end
                  end
               end
               GAP: begin
                  if (gap_end) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_adc_din_sequencer.sv
// Bench for adc_din_sequencer: directed and randomized frames checked
// against a channel-rotation / frame-timing model.
// Define ADC_DIN_AUTOSCAN_EN to run the autoscan scenario instead.

module tb_adc_din_sequencer;

   localparam int CH_W     = 3;
   localparam int WORD_W   = 16;
   localparam int ADDR_LSB = 11;
   localparam int HALF     = 2;
   localparam int GAP_CYC  = 3;
   localparam int N_CH     = 8;
   localparam int CS_LOW   = HALF + 2 * HALF * WORD_W;

   logic              clk_25M = 1'b0;
   logic              rst     = 1'b1;
   logic              start   = 1'b0;
   logic [N_CH-1:0]   ch_mask = '0;
   logic              dout    = 1'b0;
   logic              sclk;
   logic              cs_n;
   logic              Din;
   logic              busy;
   logic              data_valid;
   logic [WORD_W-1:0] data;
   logic [CH_W-1:0]   data_ch;

   int n_cmp    = 0;
   int n_err    = 0;
   int ref_last = -1;

   adc_din_sequencer #(
      .CH_W(CH_W), .WORD_W(WORD_W), .ADDR_LSB(ADDR_LSB), .HALF(HALF), .GAP_CYC(GAP_CYC)
   ) dut (
      .clk_25M(clk_25M), .rst(rst), .start(start), .ch_mask(ch_mask), .dout(dout),
      .sclk(sclk), .cs_n(cs_n), .Din(Din), .busy(busy), .data_valid(data_valid),
      .data(data), .data_ch(data_ch)
   );

   always #20 clk_25M = ~clk_25M;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Next enabled channel after the last served one (from 0 after reset)
   function automatic int exp_channel(input logic [N_CH-1:0] mask);
      int s;
      s = (ref_last < 0) ? 0 : ref_last + 1;
      for (int k = 0; k < N_CH; k++)
         if (mask[(s + k) % N_CH]) return (s + k) % N_CH;
      return -1;
   endfunction

   task automatic check_idle(input string tag);
      check({tag, "_cs_n"}, 32'(cs_n), 32'd1);
      check({tag, "_sclk"}, 32'(sclk), 32'd1);
      check({tag, "_din"},  32'(Din),  32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_dv"},   32'(data_valid), 32'd0);
      check({tag, "_data"}, 32'(data), 32'd0);
      check({tag, "_ch"},   32'(data_ch), 32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      start = 1'b0;
      @(negedge clk_25M);
      check_idle("rst");
      rst = 1'b0;
      ref_last = -1;
   endtask

   // One start-launched frame; noise adds start pulses and mask churn while busy
   task automatic do_frame(input logic [N_CH-1:0] mask, input logic [WORD_W-1:0] pat,
                           input bit noise);
      int exp_ch, cs_low, rises, falls, dv_cnt, din_bad, dv_pos_bad, gap_busy, extra;
      logic [WORD_W-1:0] exp_word, din_word, got_data;
      logic [CH_W-1:0] got_ch;
      logic prev_sclk, prev_cs, prev_din;
      bit done;
      exp_ch   = exp_channel(mask);
      exp_word = WORD_W'(exp_ch << ADDR_LSB);
      cs_low = 0; rises = 0; falls = 0; dv_cnt = 0; din_bad = 0; dv_pos_bad = 0;
      gap_busy = 0; extra = 0; din_word = '0; got_data = '0; got_ch = '0; done = 0;
      prev_sclk = 1'b1; prev_cs = 1'b1; prev_din = 1'b0;
      ch_mask = mask;
      start = 1'b1;
      @(negedge clk_25M);
      start = 1'b0;
      for (int cyc = 0; cyc < 300 && !done; cyc++) begin
         if (!cs_n) cs_low++;
         if (sclk && !prev_sclk) begin
            rises++;
            din_word = {din_word[WORD_W-2:0], Din};
         end
         if (!cs_n && !prev_cs && (Din !== prev_din) && !(prev_sclk && !sclk)) din_bad++;
         if (!sclk && prev_sclk) begin
            if (falls < WORD_W) dout = pat[WORD_W-1-falls];
            falls++;
         end
         if (data_valid) begin
            dv_cnt++;
            got_data = data;
            got_ch   = data_ch;
            if (!(cs_n && !prev_cs)) dv_pos_bad++;
         end
         if (cs_n && busy) gap_busy++;
         if (!busy && cs_low > 0) done = 1;
         prev_sclk = sclk; prev_cs = cs_n; prev_din = Din;
         if (!done) begin
            if (noise) begin
               start   = 1'($urandom);
               ch_mask = N_CH'($urandom);
            end
            @(negedge clk_25M);
         end
      end
      start = 1'b0;
      ch_mask = mask;
      check("frame_done", 32'(done), 32'd1);
      check("cs_low",     32'(cs_low), 32'(CS_LOW));
      check("rises",      32'(rises), 32'(WORD_W));
      check("din_word",   32'(din_word), 32'(exp_word));
      check("din_stable", 32'(din_bad), 32'd0);
      check("dv_count",   32'(dv_cnt), 32'd1);
      check("dv_pos",     32'(dv_pos_bad), 32'd0);
      check("data",       32'(got_data), 32'(pat));
      check("data_ch",    32'(got_ch), 32'(exp_ch));
      check("gap_len",    32'(gap_busy), 32'(GAP_CYC));
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_25M);
         if (!cs_n || busy || data_valid) extra++;
      end
      check("no_extra",   32'(extra), 32'd0);
      check("data_hold",  32'(data), 32'(pat));
      ref_last = exp_ch;
   endtask

`ifndef ADC_DIN_AUTOSCAN_EN
   // Abort a frame with reset during bit period 8
   task automatic reset_mid(input logic [N_CH-1:0] mask);
      int rises, bad;
      logic prev_sclk;
      bit hit;
      rises = 0; bad = 0; hit = 0; prev_sclk = 1'b1;
      ch_mask = mask;
      start = 1'b1;
      @(negedge clk_25M);
      start = 1'b0;
      for (int cyc = 0; cyc < 200 && !hit; cyc++) begin
         if (sclk && !prev_sclk) rises++;
         prev_sclk = sclk;
         if (rises == 8 && !sclk) hit = 1;
         else @(negedge clk_25M);
      end
      check("mid_reached", 32'(hit), 32'd1);
      rst = 1'b1;
      @(negedge clk_25M);
      rst = 1'b0;
      check_idle("mid_rst");
      ref_last = -1;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk_25M);
         if (data_valid || busy || !cs_n) bad++;
      end
      check("mid_quiet", 32'(bad), 32'd0);
   endtask
`endif

   initial begin
      do_reset();
`ifdef ADC_DIN_AUTOSCAN_EN
      begin
         int chs[$];
         int gaps[$];
         int hi_run;
         int exp_seq[3];
         logic prev_cs;
         hi_run = 0; prev_cs = 1'b1;
         for (int i = 0; i < 3; i++) begin
            exp_seq[i] = exp_channel(8'h0C);
            ref_last = exp_seq[i];
         end
         ch_mask = 8'h0C;
         start = 1'b1;
         @(negedge clk_25M);
         start = 1'b0;
         for (int cyc = 0; cyc < 1000; cyc++) begin
            if (data_valid) begin
               chs.push_back(int'(data_ch));
               if (chs.size() == 3) ch_mask = '0;
            end
            if (cs_n && busy) hi_run++;
            if (!cs_n && prev_cs && chs.size() > 0) gaps.push_back(hi_run);
            if (!cs_n) hi_run = 0;
            if (!busy && chs.size() >= 3) break;
            prev_cs = cs_n;
            @(negedge clk_25M);
         end
         while (chs.size() < 3) chs.push_back(-1);
         while (gaps.size() < 2) gaps.push_back(-1);
         check("as_frames", 32'(chs.size()), 32'd3);
         for (int i = 0; i < 3; i++) check("as_ch", 32'(chs[i]), 32'(exp_seq[i]));
         check("as_gap0", 32'(gaps[0]), 32'(GAP_CYC));
         check("as_gap1", 32'(gaps[1]), 32'(GAP_CYC));
         check("as_busy_end", 32'(busy), 32'd0);
      end
`else
      do_frame(8'h20, 16'hA5C3, 1'b0);
      do_reset();
      for (int i = 0; i < 3; i++) do_frame(8'h81, WORD_W'($urandom), 1'b0);
      begin
         int bad;
         bad = 0;
         ch_mask = '0;
         start = 1'b1;
         for (int i = 0; i < 6; i++) begin
            @(negedge clk_25M);
            if (busy || !cs_n || !sclk || data_valid) bad++;
         end
         start = 1'b0;
         check("mask0_ignored", 32'(bad), 32'd0);
      end
      for (int i = 0; i < 8; i++)
         do_frame(N_CH'($urandom_range(1, 255)), WORD_W'($urandom), 1'b1);
      reset_mid(8'h68);
      do_frame(8'h68, WORD_W'($urandom), 1'b0);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
